fifo_arbiter: RTL and testbench

Four-input round-robin arbiter sitting directly downstream of four `fifo` instances (BUF_WIDTH=3, 4-bit words) and upstream of a single output `fifo`. It pops words from non-empty input FIFOs in fair rotation, respecting output back-pressure via the output FIFO's `almost_full`. It forwards each word, with a fixed two-cycle pipeline, as a write into the output FIFO.

---
 rtl/fifo_arbiter_pkg.sv | 30 +++
 rtl/fifo_arbiter_rr_pick4.sv | 28 ++
 rtl/fifo_arbiter.sv | 97 +++++++++
 tb/tb_fifo_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbiter_pkg.sv
// Shared constants, types and one-hot helpers for the four-input FIFO arbiter.
// Imported by the round-robin picker and the arbiter top level.
package fifo_arbiter_pkg;

  localparam int unsigned ARB_N_IN  = 4;
  localparam int unsigned ARB_IDX_W = 2;

  typedef logic [ARB_IDX_W-1:0] arb_idx_t;
  // Extra MSB lets "no previous grant" sit outside the index range.
  typedef logic [ARB_IDX_W:0]   last_grant_t;

  localparam last_grant_t LAST_NONE = 3'b100;

  function automatic logic [ARB_N_IN-1:0] idx_to_onehot(arb_idx_t idx);
    logic [ARB_N_IN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic arb_idx_t onehot_to_idx(logic [ARB_N_IN-1:0] oh);
    arb_idx_t idx;
    idx = '0;
    for (int i = 0; i < ARB_N_IN; i++) begin
      if (oh[i]) idx |= arb_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick4.sv
// Combinational round-robin selector: first set bit of elig scanning from ptr upwards,
// wrapping modulo four.
module rr_pick4
  import fifo_arbiter_pkg::*;
(
  input  logic [ARB_N_IN-1:0] elig,
  input  arb_idx_t            ptr,
  output logic                found,
  output arb_idx_t            idx
);

  arb_idx_t cand;

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = ARB_N_IN - 1; k >= 0; k--) begin
      cand = ptr + arb_idx_t'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter popping four upstream FIFOs into one downstream FIFO through a
// fixed two-stage pipeline, honouring the downstream almost_full back-pressure.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned N_IN       = ARB_N_IN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arb_en,
  input  logic [N_IN-1:0]            in_empty,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  output logic [N_IN-1:0]            in_rd_en,
  input  logic                       out_almost_full,
  output logic                       out_wr_en,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ARB_IDX_W-1:0]       out_src,
  output logic                       idle
);

  logic [N_IN-1:0]       elig;
  logic                  pick_found;
  arb_idx_t              pick_idx;
  logic                  grant;

  logic [N_IN-1:0]       rd_en_q, rd_en_d;
  arb_idx_t              ptr_q, ptr_d;
  last_grant_t           last_q, last_d;

  arb_idx_t              s1_sel_q;
  logic                  s1_vld_q;

  logic                  wr_q;
  logic [DATA_WIDTH-1:0] data_q;
  arb_idx_t              src_q;

  logic [DATA_WIDTH-1:0] in_word [N_IN];

  // in_empty lags a pop by one cycle, so the input popped last cycle sits out one round.
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign elig[i]    = ~in_empty[i] & (last_q != last_grant_t'(i));
    assign in_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick4 u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    grant   = arb_en & ~out_almost_full & pick_found;
    rd_en_d = '0;
    ptr_d   = ptr_q;
    last_d  = LAST_NONE;
    if (grant) begin
      rd_en_d = idx_to_onehot(pick_idx);
      ptr_d   = pick_idx + arb_idx_t'(1);
      last_d  = {1'b0, pick_idx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q  <= '0;
      ptr_q    <= '0;
      last_q   <= LAST_NONE;
      s1_sel_q <= '0;
      s1_vld_q <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
    end else begin
      rd_en_q  <= rd_en_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      // Stage 1: the popped word appears on in_data while this stage holds its index.
      s1_vld_q <= |rd_en_q;
      s1_sel_q <= onehot_to_idx(rd_en_q);
      // Stage 2: data/source only move with a valid word to keep the write bus quiet.
      wr_q     <= s1_vld_q;
      if (s1_vld_q) begin
        data_q <= in_word[s1_sel_q];
        src_q  <= s1_sel_q;
      end
    end
  end

  assign in_rd_en  = rd_en_q;
  assign out_wr_en = wr_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign idle      = ~(|rd_en_q | s1_vld_q | wr_q) & (&in_empty);

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural upstream FIFOs, a grant-list reference model and
// directed plus randomized phases with a per-cycle comparison.
module tb_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst, arb_en, out_almost_full;
  logic [3:0]  in_empty;
  logic [15:0] in_data;
  logic [3:0]  in_rd_en;
  logic        out_wr_en;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        idle;

  always #5 clk = ~clk;

  fifo_arbiter #(
    .DATA_WIDTH (4),
    .N_IN       (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .arb_en          (arb_en),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .in_rd_en        (in_rd_en),
    .out_almost_full (out_almost_full),
    .out_wr_en       (out_wr_en),
    .out_data        (out_data),
    .out_src         (out_src),
    .idle            (idle)
  );

  // Upstream FIFO contents and their buf_out registers.
  logic [3:0] fq [4][$];
  logic [3:0] bout [4];

  // Each grant becomes one expected write, visible after edge wcyc.
  typedef struct {
    int         wcyc;
    int         src;
    logic [3:0] data;
  } exp_t;
  exp_t eq[$];

  typedef struct {
    logic [3:0] data;
    int         src;
    int         cyc;
  } cap_t;
  cap_t cap[$];

  int   cyc;
  int   m_ptr, m_last;
  bit   m_rst_seen;
  int   n_chk, n_fail;

  bit         s_rst, s_arb, s_oaf;
  bit         s_push [4];
  logic [3:0] s_pval [4];

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 4; i++) begin
      in_empty[i]        = (fq[i].size() == 0);
      in_data[i*4 +: 4]  = bout[i];
    end
  endtask

  task automatic compare();
    logic [3:0] exp_rd;
    bit         exp_wr, busy;
    int         ed, es;
    while (eq.size() > 0 && eq[0].wcyc < cyc) void'(eq.pop_front());
    exp_rd = '0;
    exp_wr = 1'b0;
    busy   = (eq.size() != 0);
    ed     = 0;
    es     = 0;
    foreach (eq[j]) begin
      if (eq[j].wcyc == cyc + 2) exp_rd[eq[j].src] = 1'b1;
      if (eq[j].wcyc == cyc) begin
        exp_wr = 1'b1;
        ed     = eq[j].data;
        es     = eq[j].src;
      end
    end
    chk("in_rd_en", in_rd_en, exp_rd);
    chk("out_wr_en", out_wr_en, exp_wr);
    if (exp_wr) begin
      chk("out_data", out_data, ed);
      chk("out_src", out_src, es);
    end
    if (m_rst_seen) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
    end
    chk("idle", idle, (!busy && (&in_empty)) ? 1 : 0);
    if (out_wr_en) cap.push_back('{data: out_data, src: int'(out_src), cyc: cyc});
  endtask

  // One clock: decide the model's grant from current inputs, step the FIFOs across the
  // edge, then compare on the falling edge.
  task automatic tick();
    logic [3:0] rd_s;
    bit         found;
    int         g;
    exp_t       e;
    rst             = s_rst;
    arb_en          = s_arb;
    out_almost_full = s_oaf;
    rd_s            = in_rd_en;
    found           = 1'b0;
    g               = 0;
    if (s_rst) begin
      eq.delete();
      m_ptr  = 0;
      m_last = -1;
    end else if (s_arb && !s_oaf) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!found && !in_empty[c] && c != m_last) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (found) begin
        e.wcyc = cyc + 3;
        e.src  = g;
        e.data = fq[g][0];
        eq.push_back(e);
        m_ptr  = (g + 1) % 4;
        m_last = g;
      end else begin
        m_last = -1;
      end
    end else begin
      m_last = -1;
    end
    m_rst_seen = s_rst;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (s_rst) begin
        fq[i].delete();
        bout[i] = '0;
      end else begin
        if (rd_s[i] && fq[i].size() > 0) bout[i] = fq[i].pop_front();
        if (s_push[i] && fq[i].size() < 8) fq[i].push_back(s_pval[i]);
      end
      s_push[i] = 1'b0;
    end
    drive_fifos();
    @(negedge clk);
    compare();
  endtask

  task automatic push4(bit p0, bit p1, bit p2, bit p3, int v0, int v1, int v2, int v3);
    s_push[0] = p0; s_pval[0] = 4'(v0);
    s_push[1] = p1; s_pval[1] = 4'(v1);
    s_push[2] = p2; s_pval[2] = 4'(v2);
    s_push[3] = p3; s_pval[3] = 4'(v3);
  endtask

  task automatic drain();
    int n;
    n     = 0;
    s_rst = 1'b0;
    s_arb = 1'b1;
    s_oaf = 1'b0;
    while (n < 200 && !(idle && eq.size() == 0)) begin
      tick();
      n++;
    end
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    int rot_d [8];
    int cnt, total_push, seg_prob, oaf_run;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    m_ptr  = 0;
    m_last = -1;
    for (int i = 0; i < 4; i++) begin
      bout[i]   = '0;
      s_push[i] = 1'b0;
      s_pval[i] = '0;
    end
    rst = 1'b1; arb_en = 1'b0; out_almost_full = 1'b0;
    drive_fifos();

    // Reset, load every FIFO, then reset again with data present.
    s_rst = 1'b1; s_arb = 1'b0; s_oaf = 1'b0;
    tick();
    s_rst = 1'b0;
    push4(1, 1, 1, 1, 1, 2, 3, 4);
    tick();
    s_rst = 1'b1; s_arb = 1'b1;
    tick();
    tick();
    chk("reset_rd_en", in_rd_en, 0);
    chk("reset_wr_en", out_wr_en, 0);
    chk("reset_data", out_data, 0);
    chk("reset_src", out_src, 0);

    // Rotation over preloaded FIFOs.
    s_rst = 1'b0; s_arb = 1'b0;
    push4(1, 1, 1, 1, 1, 3, 5, 7);
    tick();
    push4(1, 1, 1, 1, 2, 4, 6, 8);
    tick();
    cap.delete();
    s_arb = 1'b1;
    repeat (14) tick();
    rot_d = '{1, 3, 5, 7, 2, 4, 6, 8};
    chk("rot_count", cap.size(), 8);
    if (cap.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("rot_data", cap[j].data, rot_d[j]);
        chk("rot_src", cap[j].src, j % 4);
        chk("rot_spacing", cap[j].cyc - cap[0].cyc, j);
      end
    end
    drain();

    // Single source: one write every other cycle.
    s_arb = 1'b0;
    push4(0, 0, 1, 0, 0, 0, 9, 0);  tick();
    push4(0, 0, 1, 0, 0, 0, 10, 0); tick();
    push4(0, 0, 1, 0, 0, 0, 11, 0); tick();
    cap.delete();
    s_arb = 1'b1;
    repeat (12) tick();
    chk("single_count", cap.size(), 3);
    if (cap.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk("single_data", cap[j].data, 9 + j);
        chk("single_src", cap[j].src, 2);
        chk("single_gap", cap[j].cyc - cap[0].cyc, 2 * j);
      end
    end
    drain();

    // Back-pressure mid-stream, then release.
    s_arb = 1'b0;
    total_push = 0;
    for (int r = 0; r < 3; r++) begin
      push4(1, 1, 1, 1, r, r + 4, r + 8, r + 12);
      total_push += 4;
      tick();
    end
    cap.delete();
    s_arb = 1'b1;
    repeat (3) tick();
    cnt   = cap.size();
    s_oaf = 1'b1;
    repeat (6) tick();
    chk("bp_tail_le2", (cap.size() - cnt) <= 2 ? 1 : 0, 1);
    chk("bp_quiet", out_wr_en, 0);
    s_oaf = 1'b0;
    drain();
    chk("bp_total", cap.size(), total_push);

    // Gating: arb_en low for three cycles with data present.
    s_arb = 1'b0;
    push4(1, 1, 0, 0, 5, 6, 0, 0); tick();
    push4(1, 1, 0, 0, 7, 8, 0, 0); tick();
    s_arb = 1'b1;
    tick();
    s_arb = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("gate_rd_en", in_rd_en, 0);
      chk("gate_idle", idle, 0);
    end
    drain();

    // Reset mid-stream, then confirm the pointer restarts at input 0.
    s_arb = 1'b0;
    push4(1, 1, 1, 1, 1, 2, 3, 4); tick();
    s_arb = 1'b1;
    tick();
    tick();
    s_rst = 1'b1;
    tick();
    chk("rst_mid_wr_en", out_wr_en, 0);
    s_rst = 1'b0; s_arb = 1'b0;
    push4(1, 0, 0, 1, 12, 0, 0, 13); tick();
    s_arb = 1'b1;
    tick();
    chk("rst_ptr_first", in_rd_en, 1);
    drain();

    // Randomized traffic with back-pressure, gating and occasional resets.
    oaf_run  = 0;
    seg_prob = 5;
    for (int t = 0; t < 3000; t++) begin
      if (t % 400 == 0) seg_prob = $urandom_range(1, 9);
      s_rst = ($urandom_range(0, 299) == 0);
      s_arb = ($urandom_range(0, 7) != 0);
      if (oaf_run > 0) oaf_run--;
      else if ($urandom_range(0, 19) == 0) oaf_run = $urandom_range(1, 6);
      s_oaf = (oaf_run > 0);
      for (int i = 0; i < 4; i++) begin
        s_push[i] = ($urandom_range(0, 9) < seg_prob);
        s_pval[i] = 4'($urandom);
      end
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
